// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle shared by the message-path blocks.
`timescale 1ns/1ps
interface avalon_st_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  logic [DATA_W-1:0]  data;
  logic [EMPTY_W-1:0] empty;
  logic               sop;
  logic               eop;
  logic               valid;
  logic               ready;

  modport master (output data, empty, sop, eop, valid, input ready);
  modport slave  (input data, empty, sop, eop, valid, output ready);
endinterface

// File: rtl/msg_injector.sv
// Merges a main and an injected Avalon-ST message stream at message boundaries.
// Optional message/orphan statistics counters are built when MSG_INJECTOR_STATS_EN is defined.
`timescale 1ns/1ps
module msg_injector #(
  parameter int CNT_W          = 16,
  parameter int MAX_INJ_CONSEC = 4
) (
  input  logic             clk,
  input  logic             rst,
  avalon_st_if.slave       msg_in,
  avalon_st_if.slave       inj_in,
  avalon_st_if.master      msg_out,
  output logic             inject_indication,
  output logic [CNT_W-1:0] main_msg_cnt,
  output logic [CNT_W-1:0] inj_msg_cnt,
  output logic [CNT_W-1:0] orphan_cnt
);

  localparam logic [7:0] MAX_C = 8'(MAX_INJ_CONSEC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAIN = 2'd1,
    ST_INJ  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] consec_q;
  logic       inj_ind_q;

  logic main_req, inj_req;
  logic main_orphan, inj_orphan;
  logic main_done, inj_done;
  logic consec_clr;

  function automatic logic [7:0] consec_inc(input logic [7:0] c);
    return (c < MAX_C) ? c + 8'd1 : MAX_C;
  endfunction

  assign main_req = msg_in.valid & msg_in.sop;
  assign inj_req  = inj_in.valid & inj_in.sop;

  always_comb begin
    state_d       = state_q;
    msg_in.ready  = 1'b0;
    inj_in.ready  = 1'b0;
    msg_out.valid = 1'b0;
    msg_out.data  = '0;
    msg_out.empty = '0;
    msg_out.sop   = 1'b0;
    msg_out.eop   = 1'b0;
    main_orphan   = 1'b0;
    inj_orphan    = 1'b0;
    main_done     = 1'b0;
    inj_done      = 1'b0;
    consec_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Mid-message beats seen while idle belong to no granted message: drop them.
        main_orphan  = msg_in.valid & ~msg_in.sop & ~rst;
        inj_orphan   = inj_in.valid & ~inj_in.sop & ~rst;
        msg_in.ready = main_orphan;
        inj_in.ready = inj_orphan;
        if (inj_req && (!main_req || consec_q < MAX_C)) begin
          state_d = ST_INJ;
        end else if (main_req) begin
          state_d    = ST_MAIN;
          consec_clr = 1'b1;
        end
      end
      ST_MAIN: begin
        msg_out.valid = msg_in.valid;
        msg_out.data  = msg_in.data;
        msg_out.empty = msg_in.empty;
        msg_out.sop   = msg_in.sop;
        msg_out.eop   = msg_in.eop;
        msg_in.ready  = msg_out.ready;
        main_done     = msg_in.valid & msg_out.ready & msg_in.eop;
        if (main_done) state_d = ST_IDLE;
      end
      ST_INJ: begin
        msg_out.valid = inj_in.valid;
        msg_out.data  = inj_in.data;
        msg_out.empty = inj_in.empty;
        msg_out.sop   = inj_in.sop;
        msg_out.eop   = inj_in.eop;
        inj_in.ready  = msg_out.ready;
        inj_done      = inj_in.valid & msg_out.ready & inj_in.eop;
        if (inj_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbitration register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      inj_ind_q <= 1'b0;
      consec_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      inj_ind_q <= (state_d == ST_INJ);
      if (consec_clr)    consec_q <= 8'd0;
      else if (inj_done) consec_q <= consec_inc(consec_q);
    end
  end

  assign inject_indication = inj_ind_q;

`ifdef MSG_INJECTOR_STATS_EN
  logic [CNT_W-1:0] main_cnt_q, inj_cnt_q, orphan_cnt_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_cnt_q   <= '0;
      inj_cnt_q    <= '0;
      orphan_cnt_q <= '0;
    end else begin
      if (main_done) main_cnt_q <= sat_add(main_cnt_q, 2'd1);
      if (inj_done)  inj_cnt_q  <= sat_add(inj_cnt_q, 2'd1);
      if (main_orphan || inj_orphan)
        orphan_cnt_q <= sat_add(orphan_cnt_q, {1'b0, main_orphan} + {1'b0, inj_orphan});
    end
  end

  assign main_msg_cnt = main_cnt_q;
  assign inj_msg_cnt  = inj_cnt_q;
  assign orphan_cnt   = orphan_cnt_q;
`else
  assign main_msg_cnt = '0;
  assign inj_msg_cnt  = '0;
  assign orphan_cnt   = '0;
`endif

endmodule

// File: tb/tb_msg_injector.sv
// Scoreboard bench for msg_injector: directed messages, queued expectations, decoupled monitor.
`timescale 1ns/1ps
module tb_msg_injector;
  localparam int CNT_W = 16;
  localparam int MAXC  = 2;
`ifdef MSG_INJECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       empty;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct packed {
    beat_t b;
    logic  inj;
  } exp_t;

  logic clk, rst;
  logic inject_indication;
  logic [CNT_W-1:0] main_msg_cnt, inj_msg_cnt, orphan_cnt;

  avalon_st_if #(.DATA_W(8), .EMPTY_W(1)) m_if ();
  avalon_st_if #(.DATA_W(8), .EMPTY_W(1)) i_if ();
  avalon_st_if #(.DATA_W(8), .EMPTY_W(1)) o_if ();

  msg_injector #(.CNT_W(CNT_W), .MAX_INJ_CONSEC(MAXC)) dut (
    .clk               (clk),
    .rst               (rst),
    .msg_in            (m_if),
    .inj_in            (i_if),
    .msg_out           (o_if),
    .inject_indication (inject_indication),
    .main_msg_cnt      (main_msg_cnt),
    .inj_msg_cnt       (inj_msg_cnt),
    .orphan_cnt        (orphan_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t m_q[$];
  beat_t i_q[$];
  exp_t  exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] ec(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic push_m(input logic [7:0] d, input logic s, input logic e, input logic em);
    beat_t b;
    b = '{data: d, empty: em, sop: s, eop: e};
    m_q.push_back(b);
  endtask

  task automatic push_i(input logic [7:0] d, input logic s, input logic e, input logic em);
    beat_t b;
    b = '{data: d, empty: em, sop: s, eop: e};
    i_q.push_back(b);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic s, input logic e,
                             input logic em, input logic inj);
    exp_t x;
    x.b   = '{data: d, empty: em, sop: s, eop: e};
    x.inj = inj;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_q.size() != 0 || i_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain timeout pending_exp=%0d required=0", name, exp_q.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Source drivers: present queue heads, retire on a handshake seen before the edge
  initial begin
    logic hs_m, hs_i;
    m_if.valid = 1'b0; m_if.data = '0; m_if.empty = '0; m_if.sop = 1'b0; m_if.eop = 1'b0;
    i_if.valid = 1'b0; i_if.data = '0; i_if.empty = '0; i_if.sop = 1'b0; i_if.eop = 1'b0;
    forever begin
      @(negedge clk);
      hs_m = m_if.valid && m_if.ready;
      hs_i = i_if.valid && i_if.ready;
      @(posedge clk);
      #1;
      if (hs_m && m_q.size() > 0) void'(m_q.pop_front());
      if (hs_i && i_q.size() > 0) void'(i_q.pop_front());
      if (m_q.size() > 0) begin
        {m_if.data, m_if.empty, m_if.sop, m_if.eop} = m_q[0];
        m_if.valid = 1'b1;
      end else begin
        m_if.valid = 1'b0;
      end
      if (i_q.size() > 0) begin
        {i_if.data, i_if.empty, i_if.sop, i_if.eop} = i_q[0];
        i_if.valid = 1'b1;
      end else begin
        i_if.valid = 1'b0;
      end
    end
  end

  // Monitor: every accepted output beat is matched against the scoreboard head
  always @(negedge clk) begin
    if (!rst && o_if.valid && o_if.ready) begin
      exp_t got, want;
      got.b   = '{data: o_if.data, empty: o_if.empty, sop: o_if.sop, eop: o_if.eop};
      got.inj = inject_indication;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got=%0h expected=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL out_beat got data=%0h em=%0b sop=%0b eop=%0b inj=%0b expected data=%0h em=%0b sop=%0b eop=%0b inj=%0b",
                   got.b.data, got.b.empty, got.b.sop, got.b.eop, got.inj,
                   want.b.data, want.b.empty, want.b.sop, want.b.eop, want.inj);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    o_if.ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(o_if.valid), 32'd0);
    chk("rst_inj_ind", 32'(inject_indication), 32'd0);
    chk("rst_main_ready", 32'(m_if.ready), 32'd0);
    chk("rst_inj_ready", 32'(i_if.ready), 32'd0);
    chk("rst_cnt_main", 32'(main_msg_cnt), 32'd0);
    chk("rst_cnt_orphan", 32'(orphan_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 3-beat main message with one arbitration bubble
    push_m(8'h11, 1'b1, 1'b0, 1'b0);
    push_m(8'h12, 1'b0, 1'b0, 1'b0);
    push_m(8'h13, 1'b0, 1'b1, 1'b1);
    expect_beat(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_beat(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_beat(8'h13, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_bubble_valid", 32'(o_if.valid), 32'd0);
    chk("t1_bubble_ready", 32'(m_if.ready), 32'd0);
    @(negedge clk);
    chk("t1_first_valid", 32'(o_if.valid), 32'd1);
    chk("t1_first_data", 32'(o_if.data), 32'h11);
    wait_drain("t1", 200);
    chk("t1_main_cnt", 32'(main_msg_cnt), 32'(ec(1)));
    chk("t1_inj_ind", 32'(inject_indication), 32'd0);

    // Simultaneous sop: injected message wins, then main
    push_i(8'h21, 1'b1, 1'b0, 1'b0);
    push_i(8'h22, 1'b0, 1'b1, 1'b1);
    push_m(8'h31, 1'b1, 1'b0, 1'b0);
    push_m(8'h32, 1'b0, 1'b0, 1'b0);
    push_m(8'h33, 1'b0, 1'b1, 1'b0);
    expect_beat(8'h21, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_beat(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_beat(8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_beat(8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_beat(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain("t2", 200);
    chk("t2_inj_cnt", 32'(inj_msg_cnt), 32'(ec(1)));
    chk("t2_main_cnt", 32'(main_msg_cnt), 32'(ec(2)));

    // Fairness limit of 2: INJ INJ MAIN INJ INJ INJ
    for (int k = 0; k < 5; k++) push_i(8'h41 + 8'(k), 1'b1, 1'b1, 1'b0);
    push_m(8'h51, 1'b1, 1'b1, 1'b1);
    expect_beat(8'h41, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_beat(8'h42, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_beat(8'h51, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_beat(8'h43, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_beat(8'h44, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_beat(8'h45, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain("t3", 300);
    chk("t3_inj_cnt", 32'(inj_msg_cnt), 32'(ec(6)));
    chk("t3_main_cnt", 32'(main_msg_cnt), 32'(ec(3)));

    // Orphan on main, then orphans on both inputs at once
    push_m(8'hAB, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_orphan_ready", 32'(m_if.ready), 32'd1);
    chk("t4_orphan_valid", 32'(o_if.valid), 32'd0);
    @(negedge clk);
    chk("t4_orphan_cnt", 32'(orphan_cnt), 32'(ec(1)));
    chk("t4_ready_clear", 32'(m_if.ready), 32'd0);
    push_m(8'hCD, 1'b0, 1'b0, 1'b0);
    push_i(8'hEF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t4_dual_ready", 32'({m_if.ready, i_if.ready}), 32'd3);
    @(negedge clk);
    chk("t4_dual_cnt", 32'(orphan_cnt), 32'(ec(3)));
    chk("t4_dual_valid", 32'(o_if.valid), 32'd0);
    @(negedge clk);

    // Back-pressure for 4 cycles in the middle of an injected message
    push_i(8'h61, 1'b1, 1'b0, 1'b0);
    push_i(8'h62, 1'b0, 1'b0, 1'b0);
    push_i(8'h63, 1'b0, 1'b0, 1'b0);
    push_i(8'h64, 1'b0, 1'b1, 1'b1);
    expect_beat(8'h61, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_beat(8'h62, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_beat(8'h63, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_beat(8'h64, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    o_if.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_stall_data", 32'(o_if.data), 32'h62);
      chk("t5_stall_valid", 32'(o_if.valid), 32'd1);
      chk("t5_stall_inj_ready", 32'(i_if.ready), 32'd0);
      chk("t5_stall_ind", 32'(inject_indication), 32'd1);
    end
    chk("t5_stall_cnt", 32'(inj_msg_cnt), 32'(ec(6)));
    @(posedge clk);
    #2;
    o_if.ready = 1'b1;
    wait_drain("t5", 200);
    chk("t5_inj_cnt", 32'(inj_msg_cnt), 32'(ec(7)));

    // Reset while beat 1 of a 4-beat main message is presented
    push_m(8'h71, 1'b1, 1'b0, 1'b0);
    push_m(8'h72, 1'b0, 1'b0, 1'b0);
    push_m(8'h73, 1'b0, 1'b0, 1'b0);
    push_m(8'h74, 1'b0, 1'b1, 1'b0);
    expect_beat(8'h71, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    m_q.delete();
    m_if.valid = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 32'(o_if.valid), 32'd0);
    chk("t6_rst_ind", 32'(inject_indication), 32'd0);
    chk("t6_rst_cnt_main", 32'(main_msg_cnt), 32'd0);
    chk("t6_rst_cnt_inj", 32'(inj_msg_cnt), 32'd0);
    chk("t6_rst_cnt_orphan", 32'(orphan_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_m(8'h81, 1'b1, 1'b0, 1'b0);
    push_m(8'h82, 1'b0, 1'b1, 1'b1);
    expect_beat(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_beat(8'h82, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_drain("t6", 200);
    chk("t6_main_cnt", 32'(main_msg_cnt), 32'(ec(1)));
    chk("t6_orphan_cnt", 32'(orphan_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
